// File: rtl/fifo_rr_arbiter.sv
// Round-robin write-port arbiter and read sequencer for a 16x16 flagless fifo.
// Define FIFO_ARB_BURST_EN to let a winner keep the grant for up to 4 transfers.
module fifo_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [2:0]         grant_id,
    input  logic               rd_req,
    output logic               fifo_wr,
    output logic [DW-1:0]      fifo_din,
    output logic               fifo_rd,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] CAP = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        EMP = 2'd0,
        PAR = 2'd1,
        FUL = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_nxt_s;
    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   cand_s;
    logic [PW-1:0]   win_idx_s;
    logic            win_found_s;
    logic            issue_rd_s;
    logic            accept_s;
    logic            xfer_s;
    logic [NREQ-1:0] ready_s;
    logic [2:0]      grant_id_r;
    logic            fifo_wr_r;
    logic [DW-1:0]   fifo_din_r;
    logic            fifo_rd_r;
    logic            full_s;
    logic            empty_s;

`ifdef FIFO_ARB_BURST_EN
    logic [1:0]      burst_cnt_r;
    logic            burst_lock_r;
    logic [PW-1:0]   lock_id_s;

    assign lock_id_s = grant_id_r[PW-1:0];
`endif

    // A full fifo can still take a word when a read drains it in the same cycle
    assign issue_rd_s = rd_req && (state_r != EMP);
    assign accept_s   = (state_r != FUL) || issue_rd_s;
    assign xfer_s     = win_found_s && accept_s;

    // Round-robin search starting just after the last winner
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {PW{1'b0}};
        cand_s      = {PW{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = PW'((int'(ptr_r) + k) % NREQ);
            if (!win_found_s && req_valid[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
`ifdef FIFO_ARB_BURST_EN
        if (burst_lock_r && req_valid[lock_id_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = lock_id_s;
        end else begin
            win_found_s = win_found_s;
        end
`endif
    end

    // One-hot ready strobe for the winner when a word can be taken
    always_comb begin
        ready_s = {NREQ{1'b0}};
        if (xfer_s) begin
            ready_s[win_idx_s] = 1'b1;
        end else begin
            ready_s = {NREQ{1'b0}};
        end
    end

    // Occupancy update from the write/read pair of this cycle
    always_comb begin
        case ({xfer_s, issue_rd_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Next state follows the next occupancy
    always_comb begin
        if (count_nxt_s == {CW{1'b0}}) begin
            state_nxt_s = EMP;
        end else if (count_nxt_s == CAP) begin
            state_nxt_s = FUL;
        end else begin
            state_nxt_s = PAR;
        end
    end

    // State and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMP;
            count_r <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Status flags decoded from the registered state
    always_comb begin
        case (state_r)
            EMP: begin
                full_s  = 1'b0;
                empty_s = 1'b1;
            end
            FUL: begin
                full_s  = 1'b1;
                empty_s = 1'b0;
            end
            default: begin
                full_s  = 1'b0;
                empty_s = 1'b0;
            end
        endcase
    end

    // Registered fifo strobes, write data, grant and rotation pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr_r  <= 1'b0;
            fifo_rd_r  <= 1'b0;
            fifo_din_r <= {DW{1'b0}};
            grant_id_r <= 3'd0;
            ptr_r      <= PW'(NREQ - 1);
        end else begin
            fifo_wr_r <= xfer_s;
            fifo_rd_r <= issue_rd_s;
            if (xfer_s) begin
                fifo_din_r <= req_data[win_idx_s*DW +: DW];
                grant_id_r <= 3'(win_idx_s);
                ptr_r      <= win_idx_s;
            end else begin
                fifo_din_r <= fifo_din_r;
                grant_id_r <= grant_id_r;
                ptr_r      <= ptr_r;
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    // Burst tracking: lock after a transfer, release after the 4th or on valid drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt_r  <= 2'd0;
            burst_lock_r <= 1'b0;
        end else if (xfer_s) begin
            if (burst_cnt_r == 2'd3) begin
                burst_cnt_r  <= 2'd0;
                burst_lock_r <= 1'b0;
            end else begin
                burst_cnt_r  <= burst_cnt_r + 2'd1;
                burst_lock_r <= 1'b1;
            end
        end else if (burst_lock_r && !req_valid[lock_id_s]) begin
            burst_cnt_r  <= 2'd0;
            burst_lock_r <= 1'b0;
        end else begin
            burst_cnt_r  <= burst_cnt_r;
            burst_lock_r <= burst_lock_r;
        end
    end
`endif

    assign req_ready = ready_s;
    assign grant_id  = grant_id_r;
    assign fifo_wr   = fifo_wr_r;
    assign fifo_din  = fifo_din_r;
    assign fifo_rd   = fifo_rd_r;
    assign count     = count_r;
    assign full      = full_s;
    assign empty     = empty_s;

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
Shares the single write port of the 16-entry, 16-bit fifo among NREQ producers using round-robin arbitration, and sequences its read port from one consumer request line. The FIFO exposes no full or empty flags, so this block keeps its own occupancy count and never issues a write to a full FIFO or a read from an empty one. It sits directly in front of the fifo instance and drives its wr, rd and din.

Parameters:
NREQ, 4, number of producers; 2..8
DW, 16, data width; must match fifo din/dout
DEPTH, 16, fifo array depth; usable capacity CAP = DEPTH-1 (one slot sacrificed by the pointer scheme)
CW, 5, width of count; must satisfy 2^CW > CAP

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  NREQ  producer i has a word
req_data  input  NREQ*DW  producer i data in slice [i*DW +: DW]
req_ready  output  NREQ  one-hot accept strobe, combinational
grant_id  output  3  index of last accepted producer, registered
rd_req  input  1  consumer wants one word this cycle
fifo_wr  output  1  write strobe to fifo, registered
fifo_din  output  DW  write data to fifo, registered
fifo_rd  output  1  read strobe to fifo, registered
count  output  CW  committed occupancy, 0..CAP
full  output  1  count == CAP
empty  output  1  count == 0

Behaviour:
- Reset (async): fifo_wr=0, fifo_rd=0, fifo_din=0, count=0, grant_id=0, rr pointer=NREQ-1 (req 0 has first priority), state=EMP.
- Accept condition: state != FUL, or a read is issued in the same cycle (ISSUE_RD).
- Arbitration is combinational. Search from (ptr+1) mod NREQ upward with wrap, and pick the first i with req_valid[i]=1.
- req_ready[i]=1 only for the winner, and only when the accept condition holds. At most one bit is set.
- A transfer occurs when req_valid[i] & req_ready[i] are both 1.
- On a transfer, on the next edge: fifo_wr<=1, fifo_din<=req_data[i], grant_id<=i, ptr<=i.
- With no transfer, fifo_wr<=0 and fifo_din holds its value.
- Write latency: 1 cycle from handshake to fifo_wr.
- Read issue (ISSUE_RD): rd_req=1 and state != EMP. On the next edge fifo_rd<=1; otherwise fifo_rd<=0. fifo data appears on fifo dout one edge after fifo_rd.
- If rd_req=1 while EMP, the request is dropped with no effect. The consumer must re-assert.
- count update each edge:
  - transfer only: count+1
  - read only: count-1
  - both: count unchanged
  - count is bounded 0..CAP by construction
- FSM, the next state computed from the next count:
  - EMP: count 0
  - PAR: count 1..CAP-1
  - FUL: count CAP
- Transitions:
  - EMP->PAR on a transfer.
  - PAR->FUL when count is CAP-1 with a transfer and no read.
  - PAR->EMP when count is 1 with a read and no transfer.
  - FUL->PAR on a read. A same-cycle transfer is allowed via the accept condition, leaving the state in FUL.
- When the FIFO is full and a read is issued, a write is accepted in the same cycle.
- Producers not selected see req_ready=0 and must hold req_valid and req_data stable.
- rst mid-operation: every register returns to its reset value immediately. Any in-flight fifo_wr or fifo_rd strobe is cancelled. The fifo is reset on the same rst.

Optional Feature:
FIFO_ARB_BURST_EN
- Defined: the winner keeps its grant for up to 4 consecutive transfers while its req_valid stays 1 and the accept condition holds. A 2-bit burst counter tracks this.
  - The pointer does not advance during the burst.
  - After the 4th transfer, or when the winner drops valid, arbitration rotates normally.
  - A FUL stall does not break the burst.
- Undefined: the pointer advances after every transfer, giving strict per-word round-robin. The burst counter logic is absent.

Test Plan:
1. Reset, then req_valid=0001 with data 0xA001 -> req_ready=0001 in the same cycle; next cycle fifo_wr=1, fifo_din=0xA001, grant_id=0, count=1, empty=0.
2. All four valid, held for 8 cycles, no reads -> accept order 0,1,2,3,0,1,2,3; grant_id follows that order; count=8. With BURST_EN: order 0,0,0,0,1,1,1,1.
3. Fill to count=15 with req 2 still valid -> full=1, req_ready=0 until a read. With rd_req=1: same-cycle accept, count stays 15, fifo_rd and fifo_wr both pulse on the next edge.
4. count=0, rd_req=1 -> fifo_rd stays 0, count stays 0. Then write 0xBEEF and rd_req=1 two cycles later -> fifo_rd=1 and count returns to 0.
5. Write 20 words and read 20 interleaved -> fifo dout matches the sequence in order across pointer wrap; count never exceeds 15 or goes below 0.
6. Assert rst while count=7 and fifo_wr=1 -> fifo_wr=0, count=0, grant_id=0 immediately; after release, req 0 has priority.
